envelope_gen: RTL and testbench

- ADSR amplitude-envelope stage placed directly downstream of the oscillator. It consumes the oscillator's unsigned Waveform sample each clock.
- A Gate input drives the envelope state machine: attack, decay, sustain, release.
- The waveform is scaled about its midpoint by the current envelope level. The result is a registered Audio sample for the mixer/DAC path.
- With zero level, output rests at the midpoint, matching the oscillator's reset level.

---
 rtl/envelope_gen.sv | 152 +++++++++++++++
 tb/tb_envelope_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_gen.sv
// envelope_gen: ADSR amplitude envelope that scales an unsigned oscillator sample about its midpoint.
// Latency: audio_o is registered, one cycle after waveform_i/level_o; level_o follows the env register directly.
// Backpressure: none, a new sample is consumed and produced every clock.
//
// Ports:
//   clk_i, rst_i                  clock and async active-high reset
//   gate_i                        note on/off, level-sensitive
//   waveform_i                    unsigned oscillator sample, MID is the zero crossing
//   attack_i/decay_i/release_i    per-clock envelope step sizes (0 = instant)
//   sustain_i                     sustain level, top bits of the envelope accumulator
//   audio_o                       scaled sample, registered
//   level_o                       top WAVE_DEPTH bits of the envelope accumulator
//   active_o                      high whenever the envelope is not idle
module envelope_gen #(
    parameter int WAVE_DEPTH = 8,
    parameter int ENV_DEPTH  = 16,
    parameter int RATE_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  gate_i,
    input  logic [WAVE_DEPTH-1:0] waveform_i,
    input  logic [RATE_DEPTH-1:0] attack_i,
    input  logic [RATE_DEPTH-1:0] decay_i,
    input  logic [RATE_DEPTH-1:0] sustain_i,
    input  logic [RATE_DEPTH-1:0] release_i,
    output logic [WAVE_DEPTH-1:0] audio_o,
    output logic [WAVE_DEPTH-1:0] level_o,
    output logic                  active_o
);

    localparam int EW = ENV_DEPTH + 1;        // one extra bit so sums never wrap
    localparam int PW = 2 * WAVE_DEPTH + 2;   // signed product width

    localparam logic [ENV_DEPTH-1:0]  ENV_MAX = '1;
    localparam logic [WAVE_DEPTH-1:0] MID     = WAVE_DEPTH'(1 << (WAVE_DEPTH - 1));
    localparam logic signed [PW-1:0]  MID_P   = PW'(1 << (WAVE_DEPTH - 1));
    localparam logic signed [PW-1:0]  TOP_P   = PW'((1 << WAVE_DEPTH) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t                  state_q, state_d;
    logic [ENV_DEPTH-1:0]    env_q, env_d;
    logic [WAVE_DEPTH-1:0]   audio_q, audio_d;

    logic [ENV_DEPTH-1:0]    target;
    logic [EW-1:0]           att_sum;
    logic [EW-1:0]           dec_floor;

    logic signed [WAVE_DEPTH:0] diff;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       scaled;

    // Sustain level sits in the top bits of the accumulator.
    assign target    = ENV_DEPTH'(sustain_i) << (ENV_DEPTH - RATE_DEPTH);
    assign att_sum   = {1'b0, env_q} + EW'(attack_i);
    assign dec_floor = {1'b0, target} + EW'(decay_i);

    // Envelope next-state. Gate changes out of ATTACK/DECAY/RELEASE take
    // priority over completion and leave env untouched on that edge.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            S_IDLE: begin
                env_d = '0;
                if (gate_i) begin
                    state_d = S_ATTACK;
                end
            end
            S_ATTACK: begin
                if (!gate_i) begin
                    state_d = S_RELEASE;
                end else if (attack_i == '0 || att_sum >= {1'b0, ENV_MAX}) begin
                    env_d   = ENV_MAX;
                    state_d = S_DECAY;
                end else begin
                    env_d = att_sum[ENV_DEPTH-1:0];
                end
            end
            S_DECAY: begin
                if (!gate_i) begin
                    state_d = S_RELEASE;
                end else if (decay_i == '0 || {1'b0, env_q} <= dec_floor) begin
                    env_d   = target;
                    state_d = S_SUSTAIN;
                end else begin
                    env_d = env_q - ENV_DEPTH'(decay_i);
                end
            end
            S_SUSTAIN: begin
                // Re-loaded every clock so live Sustain edits are followed.
                env_d = target;
                if (!gate_i) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (gate_i) begin
                    // Retrigger from the current level rather than from zero.
                    state_d = S_ATTACK;
                end else if (release_i == '0 || env_q <= ENV_DEPTH'(release_i)) begin
                    env_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    env_d = env_q - ENV_DEPTH'(release_i);
                end
            end
            default: begin
                state_d = S_IDLE;
                env_d   = '0;
            end
        endcase
    end

    // Audio: (waveform - MID) * level, floored shift back down, re-centred
    // on MID and clamped to the sample range.
    always_comb begin
        diff    = signed'({1'b0, waveform_i} - {1'b0, MID});
        prod    = PW'(diff) * PW'(signed'({1'b0, level_o}));
        scaled  = (prod >>> WAVE_DEPTH) + MID_P;
        audio_d = scaled[WAVE_DEPTH-1:0];
        if (scaled < 0) begin
            audio_d = '0;
        end else if (scaled > TOP_P) begin
            audio_d = '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            env_q   <= '0;
            audio_q <= MID;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            audio_q <= audio_d;
        end
    end

    assign level_o  = env_q[ENV_DEPTH-1 -: WAVE_DEPTH];
    assign active_o = (state_q != S_IDLE);
    assign audio_o  = audio_q;

endmodule

// File: tb/tb_envelope_gen.sv
module tb_envelope_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       gate;
    logic [7:0] wave, att, dec, sus, rel;
    logic [7:0] audio, level;
    logic       active;

    int  errors = 0;
    int  checks = 0;
    bit  rand_wave;

    // Reference model state: envelope value, phase and expected audio sample.
    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
    int m_env, m_ph, m_audio;

    envelope_gen dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .gate_i     (gate),
        .waveform_i (wave),
        .attack_i   (att),
        .decay_i    (dec),
        .sustain_i  (sus),
        .release_i  (rel),
        .audio_o    (audio),
        .level_o    (level),
        .active_o   (active)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Midpoint plus floor((w - 128) * lvl / 256), clamped to 0..255.
    function automatic int audio_ref(int w, int lvl);
        int num, q;
        num = (w - 128) * lvl;
        if (num >= 0) q = num / 256;
        else          q = -((-num + 255) / 256);
        q = 128 + q;
        if (q < 0)   q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    task automatic model_reset();
        m_env   = 0;
        m_ph    = P_IDLE;
        m_audio = 128;
    endtask

    task automatic model_step();
        int t;
        m_audio = audio_ref(int'(wave), m_env / 256);
        t = int'(sus) * 256;
        case (m_ph)
            P_IDLE: begin
                m_env = 0;
                if (gate) m_ph = P_ATT;
            end
            P_ATT: begin
                if (!gate) m_ph = P_REL;
                else if (att == 0 || m_env + int'(att) >= 65535) begin
                    m_env = 65535; m_ph = P_DEC;
                end else m_env = m_env + int'(att);
            end
            P_DEC: begin
                if (!gate) m_ph = P_REL;
                else if (dec == 0 || m_env <= t + int'(dec)) begin
                    m_env = t; m_ph = P_SUS;
                end else m_env = m_env - int'(dec);
            end
            P_SUS: begin
                m_env = t;
                if (!gate) m_ph = P_REL;
            end
            default: begin
                if (gate) m_ph = P_ATT;
                else if (rel == 0 || m_env <= int'(rel)) begin
                    m_env = 0; m_ph = P_IDLE;
                end else m_env = m_env - int'(rel);
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("level",  32'(level),  32'(m_env / 256));
        chk("active", 32'(active), 32'(m_ph != P_IDLE));
        chk("audio",  32'(audio),  32'(m_audio));
        if (rand_wave) wave = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; gate = 1'b0; wave = 8'h00;
        att = 8'h00; dec = 8'h00; sus = 8'h00; rel = 8'h00;
        rand_wave = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_audio",  32'(audio),  'h80);
        chk("rst_level",  32'(level),  'h00);
        chk("rst_active", 32'(active), 'h0);
        rst = 1'b0;

        // Full attack/decay/sustain run.
        att = 8'h80; dec = 8'h40; sus = 8'h80; gate = 1'b1;
        tick();
        repeat (511) tick();
        chk("attack_511", 32'(level), 'hFF);
        chk("attack_511_act", 32'(active), 'h1);
        tick();
        chk("attack_clamp", 32'(level), 'hFF);
        repeat (511) tick();
        chk("decay_511", 32'(level), 'h80);
        tick();
        repeat (20) tick();
        chk("sustain_hold", 32'(level), 'h80);

        // Release from sustain.
        rel = 8'h80; gate = 1'b0;
        tick();
        chk("release_entry", 32'(level), 'h80);
        repeat (255) tick();
        chk("release_255_act", 32'(active), 'h1);
        tick();
        chk("release_done_act", 32'(active), 'h0);
        chk("release_done_lvl", 32'(level), 'h00);

        // Gate drop mid-attack, then retrigger mid-release.
        att = 8'h80; gate = 1'b1;
        tick();
        for (int k = 0; k < 600 && m_env != 'h3000; k++) tick();
        chk("drop_point", 32'(level), 'h30);
        gate = 1'b0;
        tick();
        chk("drop_hold", 32'(level), 'h30);
        for (int k = 0; k < 600 && m_env != 'h2000; k++) tick();
        chk("retrig_point", 32'(level), 'h20);
        gate = 1'b1;
        tick();
        chk("retrig_hold", 32'(level), 'h20);
        chk("retrig_act", 32'(active), 'h1);
        tick();
        chk("retrig_resume", 32'(level), 'h20);

        // Asynchronous reset mid-attack at env 0x4000.
        for (int k = 0; k < 600 && m_env != 'h4000; k++) tick();
        chk("pre_reset_lvl", 32'(level), 'h40);
        @(posedge clk);
        model_step();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_audio",  32'(audio),  'h80);
        chk("async_rst_level",  32'(level),  'h00);
        chk("async_rst_active", 32'(active), 'h0);
        model_reset();
        gate = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("held_rst_level", 32'(level), 'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(active), 'h0);

        // Instant rates.
        att = 8'h00; dec = 8'h00; rel = 8'h00; sus = 8'h60; gate = 1'b1;
        tick();
        chk("inst_att_entry", 32'(level), 'h00);
        tick();
        chk("inst_att_max", 32'(level), 'hFF);
        tick();
        chk("inst_decay_t", 32'(level), 'h60);
        gate = 1'b0;
        tick();
        chk("inst_rel_entry", 32'(level), 'h60);
        tick();
        chk("inst_rel_zero", 32'(level), 'h00);
        chk("inst_rel_idle", 32'(active), 'h0);

        // Audio scaling corners.
        rand_wave = 1'b0;
        wave = 8'h80; sus = 8'hFF; gate = 1'b1;
        repeat (3) tick();
        chk("full_level", 32'(level), 'hFF);
        wave = 8'hFF;
        tick();
        chk("audio_ff_ff", 32'(audio), 'hFE);
        sus = 8'h80;
        tick();
        wave = 8'h00;
        tick();
        chk("audio_80_00", 32'(audio), 'h40);
        gate = 1'b0;
        repeat (2) tick();
        wave = 8'h37;
        tick();
        chk("audio_zero_lvl_a", 32'(audio), 'h80);
        wave = 8'hFF;
        tick();
        chk("audio_zero_lvl_b", 32'(audio), 'h80);
        rand_wave = 1'b1;

        // Randomised gate and rate activity.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) gate = ~gate;
            if ($urandom_range(0, 49) == 0) begin
                att = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                dec = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                rel = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                sus = 8'($urandom);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
